image_tx_scheduler: RTL
=======================

Name: image_tx_scheduler

Overview:
- Frame-level controller that sequences the Image_Sender pixel streamer and owns the UART transmitter it shares.
- On each capture trigger it does four things in order: sends a 3-byte frame header, enables Image_Sender, forwards its byte stream while counting and checksumming it, then sends a 1-byte checksum trailer.
- Sits between the door-event logic (trigger source) and the UART tx block; Image_Sender never drives the UART directly.

Parameters:
- WIDTH, 640, pixels per line streamed by Image_Sender.
- HEIGHT, 480, lines per frame.
- TIMEOUT, 1024, max cycles to wait for img_rdy after img_en drops, or between image bytes, before flagging an error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trigger  in  1  single-cycle capture request
- img_rdy  in  1  Image_Sender idle/ready
- img_en  out  1  Image_Sender enable
- img_tx_data  in  8  byte from Image_Sender
- img_ld_tx_data  in  1  Image_Sender load strobe
- img_tx_empty  out  1  UART-empty seen by Image_Sender
- tx_data  out  8  byte to UART
- ld_tx_data  out  1  UART load strobe
- tx_empty  in  1  UART idle
- busy  out  1  frame in progress
- frame_id  out  8  count of completed frames
- err  out  1  sticky timeout flag, cleared by next accepted trigger

Behaviour:
- Reset (async, any state): state=IDLE; img_en=0, ld_tx_data=0, tx_data=0, busy=0, frame_id=0, err=0, pending=0, byte count=0, checksum=0.
- Constant NBYTES=WIDTH*HEIGHT*3. Counter width is $clog2(NBYTES+1). Checksum is an 8-bit sum mod 256 of payload bytes only.
- Triggers:
  - In IDLE, a trigger is accepted if img_rdy=1. Otherwise it sets pending.
  - A trigger while busy sets pending (one deep; extra triggers are dropped).
  - In IDLE, pending=1 with img_rdy=1 starts a frame and clears pending.
- Header sequence: HDR0 0xA5, HDR1 0x5A, HDR2 frame_id.
- Controller-owned byte send:
  - In a send state with tx_empty=1, pulse ld_tx_data for exactly 1 cycle with tx_data valid.
  - Next state is the matching WAIT state. tx_empty is ignored for the first WAIT cycle, then the FSM waits for tx_empty=1 before advancing.
  - If tx_empty=0 on entry to a send state, stall with ld_tx_data=0.
- START: img_en=1, counter and checksum cleared, go to STREAM.
- STREAM:
  - tx_data=img_tx_data, ld_tx_data=img_ld_tx_data (combinational pass-through), img_tx_empty=tx_empty.
  - Each img_ld_tx_data pulse: counter+1, checksum+=img_tx_data.
  - When the counter reaches NBYTES, go to DRAIN.
  - A gap longer than TIMEOUT cycles between strobes: err=1, go to ABORT.
- img_tx_empty=0 in every state except STREAM.
- DRAIN:
  - img_en=0 from the cycle after the last strobe.
  - Wait for tx_empty=1 and img_rdy=1, then go to TRL.
  - If this takes more than TIMEOUT cycles: err=1, go to ABORT.
- TRL: send the checksum byte, then TRL_WAIT, then DONE.
- DONE: 1 cycle; frame_id+1 (wraps 255 to 0); go to IDLE.
- ABORT: img_en=0, no trailer sent, frame_id unchanged, go to IDLE.
- busy=1 in every state except IDLE.
- Strobes from Image_Sender outside STREAM are ignored and never reach the UART.
- Same-cycle events:
  - Last strobe in the same cycle as a trigger: the byte is counted and pending is set.
  - Trigger in the same cycle as DONE: pending is set and the new frame starts from IDLE.

Decomposition:
- Package img_tx_pkg holds:
  - the state enum (IDLE, HDR0, HDR0_W, HDR1, HDR1_W, HDR2, HDR2_W, START, STREAM, DRAIN, TRL, TRL_W, DONE, ABORT);
  - constants SYNC0=8'hA5 and SYNC1=8'h5A.
- One sub-module, uart_byte_issuer: the ld-pulse / one-cycle-blank / wait-for-tx_empty handshake, reused for the header and trailer sends.

Test Plan (WIDTH=2, HEIGHT=1, so NBYTES=6; TIMEOUT=16; UART model idle 1 cycle after load unless stated):
- Nominal frame: trigger, model streams 0x01..0x06 → UART sees A5,5A,00,01..06,15; frame_id=1; busy returns to 0; img_en high only during STREAM.
- Slow UART: tx_empty held 0 for 10 cycles after each load → no ld_tx_data while tx_empty=0; same byte sequence; no err.
- Stalled sender: stop strobes after 3 bytes → err=1 within 17 cycles; img_en=0; no trailer; frame_id unchanged; next trigger clears err and sends header 00.
- Pending trigger: trigger again during STREAM → second frame auto-starts with header byte 01 after DONE; a third trigger in the same frame is dropped.
- Checksum wrap: bytes FF,FF,FF,FF,FF,FF → trailer FA; frame_id wraps 255 to 0 after 256 frames (force-load).
- Async reset mid-STREAM: rst_n low → all outputs 0 at once, no further ld_tx_data; next trigger starts cleanly.

Source files
------------

// File: rtl/img_tx_pkg.sv
// Shared types and constants for the image frame transmit scheduler.
package img_tx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR0,
        HDR0_W,
        HDR1,
        HDR1_W,
        HDR2,
        HDR2_W,
        START,
        STREAM,
        DRAIN,
        TRL,
        TRL_W,
        DONE,
        ABORT
    } state_t;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

endpackage

// File: rtl/image_tx_scheduler_issuer.sv
// Single-byte UART handshake: load pulse when the UART is idle, then one
// blank cycle (the UART has not yet dropped tx_empty), then wait for idle.
module uart_byte_issuer (
    input  logic clk,
    input  logic rst_n,
    input  logic send,      // controller sits in a send state
    input  logic hold,      // controller sits in the matching wait state
    input  logic tx_empty,
    output logic ld,        // one-cycle UART load strobe
    output logic ack        // byte fully handed over, advance
);

    logic blank;

    // Load only when idle; acknowledge once past the blank cycle and idle again.
    always_comb begin
        ld  = send & tx_empty;
        ack = hold & ~blank & tx_empty;
    end

    // Marks the first wait cycle after a load so a stale tx_empty is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blank <= 1'b0;
        else        blank <= ld;
    end

endmodule

// File: rtl/image_tx_scheduler.sv
// Frame controller: header, Image_Sender payload pass-through with byte
// count and checksum, then checksum trailer, all over one shared UART.
module image_tx_scheduler
    import img_tx_pkg::*;
#(
    parameter int unsigned WIDTH   = 640,
    parameter int unsigned HEIGHT  = 480,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trigger,
    input  logic       img_rdy,
    output logic       img_en,
    input  logic [7:0] img_tx_data,
    input  logic       img_ld_tx_data,
    output logic       img_tx_empty,
    output logic [7:0] tx_data,
    output logic       ld_tx_data,
    input  logic       tx_empty,
    output logic       busy,
    output logic [7:0] frame_id,
    output logic       err
);

    localparam int unsigned NBYTES = WIDTH * HEIGHT * 3;
    localparam int unsigned CW     = $clog2(NBYTES + 1);
    localparam int unsigned TW     = $clog2(TIMEOUT + 1);

    state_t          state, next_state;
    logic [CW-1:0]   count;
    logic [7:0]      checksum;
    logic [TW-1:0]   timer;
    logic            pending;
    logic            send, hold, iss_ld, iss_ack;
    logic            start_frame, strobe, gap_expired, last_byte;

    uart_byte_issuer u_issuer (
        .clk      (clk),
        .rst_n    (rst_n),
        .send     (send),
        .hold     (hold),
        .tx_empty (tx_empty),
        .ld       (iss_ld),
        .ack      (iss_ack)
    );

    // Decode of the current state and qualifying events.
    always_comb begin
        send        = state inside {HDR0, HDR1, HDR2, TRL};
        hold        = state inside {HDR0_W, HDR1_W, HDR2_W, TRL_W};
        strobe      = (state == STREAM) & img_ld_tx_data;
        start_frame = (state == IDLE) & (trigger | pending) & img_rdy;
        gap_expired = (timer == TW'(TIMEOUT - 1));
        last_byte   = (count == CW'(NBYTES - 1));
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_frame) next_state = HDR0;
            HDR0:    if (iss_ld)      next_state = HDR0_W;
            HDR0_W:  if (iss_ack)     next_state = HDR1;
            HDR1:    if (iss_ld)      next_state = HDR1_W;
            HDR1_W:  if (iss_ack)     next_state = HDR2;
            HDR2:    if (iss_ld)      next_state = HDR2_W;
            HDR2_W:  if (iss_ack)     next_state = START;
            START:                    next_state = STREAM;
            STREAM: begin
                if (strobe && last_byte)        next_state = DRAIN;
                else if (!strobe && gap_expired) next_state = ABORT;
            end
            DRAIN: begin
                if (tx_empty && img_rdy) next_state = TRL;
                else if (gap_expired)    next_state = ABORT;
            end
            TRL:     if (iss_ld)      next_state = TRL_W;
            TRL_W:   if (iss_ack)     next_state = DONE;
            DONE:                     next_state = IDLE;
            ABORT:                    next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    // UART-side outputs: controller bytes in send states, sender bytes in STREAM.
    always_comb begin
        tx_data      = '0;
        ld_tx_data   = iss_ld;
        img_tx_empty = 1'b0;
        busy         = (state != IDLE);
        unique case (state)
            HDR0:    tx_data = SYNC0;
            HDR1:    tx_data = SYNC1;
            HDR2:    tx_data = frame_id;
            TRL:     tx_data = checksum;
            STREAM: begin
                tx_data      = img_tx_data;
                ld_tx_data   = img_ld_tx_data;
                img_tx_empty = tx_empty;
            end
            default: tx_data = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Frame bookkeeping: enable, watchdog, count/checksum, pending, err, frame_id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_en   <= 1'b0;
            timer    <= '0;
            count    <= '0;
            checksum <= '0;
            pending  <= 1'b0;
            err      <= 1'b0;
            frame_id <= '0;
        end else begin
            // Registered from next_state so img_en is high exactly while in STREAM.
            img_en <= (next_state == STREAM);

            if (next_state != state || strobe)         timer <= '0;
            else if (state == STREAM || state == DRAIN) timer <= timer + TW'(1);

            if (state == START) begin
                count    <= '0;
                checksum <= '0;
            end else if (strobe) begin
                count    <= count + CW'(1);
                checksum <= checksum + img_tx_data;
            end

            if (start_frame)  pending <= 1'b0;
            else if (trigger) pending <= 1'b1;

            if (start_frame)               err <= 1'b0;
            else if (next_state == ABORT)  err <= 1'b1;

            if (state == DONE) frame_id <= frame_id + 8'd1;
        end
    end

endmodule
